security_mode_controller: RTL and testbench

//  Sequences the home-security system: arming/disarming FSM, exit delay, sensor alarm, passcode check.

---
 rtl/sec_ctrl_pkg.sv | 36 +++
 rtl/sec_delay_timer.sv | 27 ++
 rtl/security_mode_controller.sv | 177 +++++++++++++++++
 tb/tb_security_mode_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sec_ctrl_pkg.sv
// Shared mode codes and FSM state type for the security controller and the display's mode decode.
package sec_ctrl_pkg;

    localparam logic [2:0] MODE_UNARM   = 3'b000;
    localparam logic [2:0] MODE_ARMS    = 3'b001;
    localparam logic [2:0] MODE_ARMA    = 3'b010;
    localparam logic [2:0] MODE_RESET   = 3'b011;
    localparam logic [2:0] MODE_DISPLAY = 3'b100;
    localparam logic [2:0] MODE_BLANK   = 3'b111;

    typedef enum logic [2:0] {
        DISARMED   = 3'd0,
        EXIT       = 3'd1,
        ARMED_STAY = 3'd2,
        ARMED_AWAY = 3'd3,
        ALARM      = 3'd4,
        CODE_ENTRY = 3'd5,
        RESET_MSG  = 3'd6
    } state_t;

    function automatic logic [2:0] mode_of(input state_t s);
        case (s)
            EXIT, ARMED_AWAY: mode_of = MODE_ARMA;
            ARMED_STAY:       mode_of = MODE_ARMS;
            ALARM:            mode_of = MODE_BLANK;
            CODE_ENTRY:       mode_of = MODE_DISPLAY;
            RESET_MSG:        mode_of = MODE_RESET;
            default:          mode_of = MODE_UNARM;
        endcase
    endfunction

    function automatic logic is_armed(input state_t s);
        is_armed = (s == EXIT) || (s == ARMED_STAY) || (s == ARMED_AWAY) || (s == ALARM);
    endfunction

endpackage

// File: rtl/sec_delay_timer.sv
// Loadable down-counter shared by the exit delay and the reset-message hold; done while count is zero.
module sec_delay_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/security_mode_controller.sv
// Arming/disarming FSM with exit delay, sensor alarm and passcode check driving the mode/msg display.
// Optional consecutive-failure lockout is enabled by defining SEC_FAIL_LOCKOUT_EN.
module security_mode_controller
    import sec_ctrl_pkg::*;
#(
    parameter logic [3:0]  PASSCODE    = 4'b1010,
    parameter int unsigned EXIT_CYCLES = 250,
    parameter int unsigned HOLD_CYCLES = 100,
    parameter int          CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_stay,
    input  logic       btn_away,
    input  logic       btn_enter,
    input  logic [3:0] code_sw,
    input  logic [1:0] sensor,
    output logic [2:0] mode,
    output logic [3:0] msg,
    output logic       armed,
    output logic       alarm
);

    localparam logic [CNT_W-1:0] EXIT_VAL = CNT_W'(EXIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    state_t           origin_q, origin_d;
    logic             btn_stay_q, btn_away_q, btn_enter_q;
    logic             started_q;
    logic [2:0]       mode_q;
    logic [3:0]       msg_q;
    logic             armed_q, alarm_q;
    logic             timer_load, timer_done;
    logic [CNT_W-1:0] timer_val;
    logic             rise_stay, rise_away, rise_enter;

`ifdef SEC_FAIL_LOCKOUT_EN
    logic [1:0] fail_cnt_q, fail_cnt_d;
`endif

    // Edges are suppressed on the first cycle after reset so a button held through reset never acts.
    assign rise_stay  = started_q & btn_stay  & ~btn_stay_q;
    assign rise_away  = started_q & btn_away  & ~btn_away_q;
    assign rise_enter = started_q & btn_enter & ~btn_enter_q;

    sec_delay_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        origin_d   = origin_q;
        timer_load = 1'b0;
        timer_val  = EXIT_VAL;
`ifdef SEC_FAIL_LOCKOUT_EN
        fail_cnt_d = fail_cnt_q;
`endif
        case (state_q)
            DISARMED: begin
                if (rise_stay) begin
                    state_d = ARMED_STAY;
                end else if (rise_away) begin
                    state_d    = EXIT;
                    timer_load = 1'b1;
                end
            end
            EXIT: begin
                if (rise_enter) begin
                    state_d  = CODE_ENTRY;
                    origin_d = EXIT;
                end else if (timer_done) begin
                    state_d = ARMED_AWAY;
                end
            end
            ARMED_STAY: begin
                if (sensor[0]) begin
                    state_d = ALARM;
                end else if (rise_enter) begin
                    state_d  = CODE_ENTRY;
                    origin_d = ARMED_STAY;
                end
            end
            ARMED_AWAY: begin
                if (|sensor) begin
                    state_d = ALARM;
                end else if (rise_enter) begin
                    state_d  = CODE_ENTRY;
                    origin_d = ARMED_AWAY;
                end
            end
            ALARM: begin
                if (rise_enter) begin
                    state_d  = CODE_ENTRY;
                    origin_d = ALARM;
                end
            end
            CODE_ENTRY: begin
                if (rise_enter) begin
                    if (code_sw == PASSCODE) begin
                        state_d    = RESET_MSG;
                        timer_load = 1'b1;
                        timer_val  = HOLD_VAL;
`ifdef SEC_FAIL_LOCKOUT_EN
                        fail_cnt_d = 2'd0;
`endif
                    end else begin
                        state_d = origin_q;
`ifdef SEC_FAIL_LOCKOUT_EN
                        if (fail_cnt_q == 2'd2) begin
                            state_d    = ALARM;
                            fail_cnt_d = 2'd0;
                        end else begin
                            fail_cnt_d = fail_cnt_q + 2'd1;
                        end
`endif
                        // Returning to EXIT restarts the full exit delay.
                        timer_load = (state_d == EXIT);
                    end
                end
            end
            RESET_MSG: begin
                if (timer_done) begin
                    state_d = DISARMED;
                end
            end
            default: state_d = DISARMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DISARMED;
            origin_q    <= DISARMED;
            btn_stay_q  <= 1'b0;
            btn_away_q  <= 1'b0;
            btn_enter_q <= 1'b0;
            started_q   <= 1'b0;
            mode_q      <= MODE_UNARM;
            msg_q       <= 4'd0;
            armed_q     <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            origin_q    <= origin_d;
            btn_stay_q  <= btn_stay;
            btn_away_q  <= btn_away;
            btn_enter_q <= btn_enter;
            started_q   <= 1'b1;
            mode_q      <= mode_of(state_d);
            msg_q       <= (state_d == CODE_ENTRY) ? code_sw : 4'd0;
            armed_q     <= is_armed(state_d);
            alarm_q     <= (state_d == ALARM) || (state_d == CODE_ENTRY && origin_d == ALARM);
        end
    end

`ifdef SEC_FAIL_LOCKOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt_q <= 2'd0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
        end
    end
`endif

    assign mode  = mode_q;
    assign msg   = msg_q;
    assign armed = armed_q;
    assign alarm = alarm_q;

endmodule

// File: tb/tb_security_mode_controller.sv
// Directed self-checking bench for security_mode_controller (PASSCODE=1010, EXIT=8, HOLD=4).
module tb_security_mode_controller;
    import sec_ctrl_pkg::*;

`ifdef SEC_FAIL_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_stay, btn_away, btn_enter;
    logic [3:0] code_sw;
    logic [1:0] sensor;
    logic [2:0] mode;
    logic [3:0] msg;
    logic       armed, alarm;

    int n_tests = 0;
    int n_fail  = 0;

    security_mode_controller #(
        .PASSCODE    (4'b1010),
        .EXIT_CYCLES (8),
        .HOLD_CYCLES (4),
        .CNT_W       (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_stay  (btn_stay),
        .btn_away  (btn_away),
        .btn_enter (btn_enter),
        .code_sw   (code_sw),
        .sensor    (sensor),
        .mode      (mode),
        .msg       (msg),
        .armed     (armed),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Correct-code disarm from an armed/alarm state; btn_enter must be low on entry.
    task automatic disarm(input string tag, input logic exp_alarm);
        code_sw   = 4'b1010;
        btn_enter = 1'b1;
        tick(1);
        check({tag, "_entry_mode"}, 32'(mode), 32'(MODE_DISPLAY));
        check({tag, "_entry_alarm"}, 32'(alarm), 32'(exp_alarm));
        btn_enter = 1'b0;
        tick(1);
        btn_enter = 1'b1;
        tick(1);
        check({tag, "_reset_mode"}, 32'(mode), 32'(MODE_RESET));
        btn_enter = 1'b0;
        tick(4);
        check({tag, "_done_mode"}, 32'(mode), 32'(MODE_UNARM));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        btn_stay  = 1'b1;
        btn_away  = 1'b1;
        btn_enter = 1'b1;
        code_sw   = 4'd0;
        sensor    = 2'b00;
        tick(3);
        check("rst_mode", 32'(mode), 32'(MODE_UNARM));
        check("rst_msg", 32'(msg), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);

        // Release reset with buttons still held: no action.
        rst_n = 1'b1;
        tick(3);
        check("held_mode", 32'(mode), 32'(MODE_UNARM));
        check("held_armed", 32'(armed), 32'd0);
        btn_stay  = 1'b0;
        btn_away  = 1'b0;
        btn_enter = 1'b0;
        tick(1);

        // Stay path.
        btn_stay = 1'b1;
        tick(1);
        check("stay_mode", 32'(mode), 32'(MODE_ARMS));
        check("stay_armed", 32'(armed), 32'd1);
        btn_stay = 1'b0;
        sensor   = 2'b10;
        tick(2);
        check("stay_interior_mode", 32'(mode), 32'(MODE_ARMS));
        check("stay_interior_alarm", 32'(alarm), 32'd0);
        sensor = 2'b01;
        tick(1);
        check("stay_trip_mode", 32'(mode), 32'(MODE_BLANK));
        check("stay_trip_alarm", 32'(alarm), 32'd1);
        sensor = 2'b00;

        // Disarm from ALARM with display payload checks.
        btn_enter = 1'b1;
        tick(1);
        check("code_mode", 32'(mode), 32'(MODE_DISPLAY));
        check("code_alarm_held", 32'(alarm), 32'd1);
        check("code_msg0", 32'(msg), 32'd0);
        btn_enter = 1'b0;
        code_sw   = 4'b1010;
        tick(1);
        check("code_msg", 32'(msg), 32'hA);
        btn_enter = 1'b1;
        tick(1);
        check("rmsg_mode", 32'(mode), 32'(MODE_RESET));
        check("rmsg_alarm", 32'(alarm), 32'd0);
        check("rmsg_armed", 32'(armed), 32'd0);
        check("rmsg_msg", 32'(msg), 32'd0);
        btn_enter = 1'b0;
        tick(3);
        check("rmsg_hold", 32'(mode), 32'(MODE_RESET));
        tick(1);
        check("rmsg_end", 32'(mode), 32'(MODE_UNARM));

        // Away path: exit delay ignores sensors, then the first armed cycle trips.
        btn_away = 1'b1;
        tick(1);
        check("away_mode", 32'(mode), 32'(MODE_ARMA));
        check("away_armed", 32'(armed), 32'd1);
        btn_away = 1'b0;
        sensor   = 2'b11;
        tick(7);
        check("exit_last_alarm", 32'(alarm), 32'd0);
        tick(1);
        check("away_armed_mode", 32'(mode), 32'(MODE_ARMA));
        check("away_armed_alarm", 32'(alarm), 32'd0);
        tick(1);
        check("away_trip_mode", 32'(mode), 32'(MODE_BLANK));
        check("away_trip_alarm", 32'(alarm), 32'd1);
        sensor = 2'b00;
        disarm("d_away", 1'b1);

        // Wrong code during EXIT restarts the full exit delay.
        btn_away = 1'b1;
        tick(1);
        btn_away = 1'b0;
        tick(3);
        code_sw   = 4'b0000;
        btn_enter = 1'b1;
        tick(1);
        check("exit_code_mode", 32'(mode), 32'(MODE_DISPLAY));
        check("exit_code_alarm", 32'(alarm), 32'd0);
        btn_enter = 1'b0;
        tick(1);
        btn_enter = 1'b1;
        tick(1);
        check("exit_back_mode", 32'(mode), 32'(MODE_ARMA));
        btn_enter = 1'b0;
        sensor    = 2'b11;
        tick(8);
        check("exit_restart_alarm", 32'(alarm), 32'd0);
        tick(1);
        check("exit_restart_trip", 32'(mode), 32'(MODE_BLANK));
        sensor = 2'b00;
        disarm("d_restart", 1'b1);

        // Wrong code from ARMED_STAY, three times.
        btn_stay = 1'b1;
        tick(1);
        btn_stay = 1'b0;
        check("wrong_stay_mode", 32'(mode), 32'(MODE_ARMS));
        code_sw = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            btn_enter = 1'b1;
            tick(1);
            check("wrong_entry_mode", 32'(mode), 32'(MODE_DISPLAY));
            check("wrong_entry_msg", 32'(msg), 32'h6);
            btn_enter = 1'b0;
            tick(1);
            btn_enter = 1'b1;
            tick(1);
            if (LOCKOUT && i == 2) begin
                check("lockout_mode", 32'(mode), 32'(MODE_BLANK));
                check("lockout_alarm", 32'(alarm), 32'd1);
            end else begin
                check("wrong_back_mode", 32'(mode), 32'(MODE_ARMS));
                check("wrong_back_alarm", 32'(alarm), 32'd0);
            end
            btn_enter = 1'b0;
            tick(1);
        end
        disarm("d_wrong", LOCKOUT);

        // Stay and away rise together: stay wins.
        btn_stay = 1'b1;
        btn_away = 1'b1;
        tick(1);
        check("both_mode", 32'(mode), 32'(MODE_ARMS));
        btn_stay = 1'b0;
        btn_away = 1'b0;
        tick(1);
        check("both_settled", 32'(mode), 32'(MODE_ARMS));
        disarm("d_both", 1'b0);

        // Sensor and enter together in ARMED_AWAY: sensor wins.
        btn_away = 1'b1;
        tick(1);
        btn_away = 1'b0;
        tick(8);
        check("coll_armed", 32'(mode), 32'(MODE_ARMA));
        sensor    = 2'b10;
        btn_enter = 1'b1;
        tick(1);
        check("coll_mode", 32'(mode), 32'(MODE_BLANK));
        check("coll_alarm", 32'(alarm), 32'd1);
        sensor    = 2'b00;
        btn_enter = 1'b0;
        tick(1);
        check("coll_stays", 32'(mode), 32'(MODE_BLANK));

        // Reset pulse in the middle of RESET_MSG.
        code_sw   = 4'b1010;
        btn_enter = 1'b1;
        tick(1);
        btn_enter = 1'b0;
        tick(1);
        btn_enter = 1'b1;
        tick(1);
        check("mid_rmsg", 32'(mode), 32'(MODE_RESET));
        btn_enter = 1'b0;
        tick(1);
        rst_n = 1'b0;
        #2;
        check("async_rst_mode", 32'(mode), 32'(MODE_UNARM));
        check("async_rst_armed", 32'(armed), 32'd0);
        check("async_rst_alarm", 32'(alarm), 32'd0);
        rst_n = 1'b1;
        tick(5);
        check("post_rst_mode", 32'(mode), 32'(MODE_UNARM));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
